// File: rtl/boot_multi_loader_if.sv
// Core bus seen by the boot copier: word address, read/write data,
// active-low request and active-low wait.
//
// Handshake: the master offers an access by driving n_req=0 together with
// a, wen and (for writes) dout; the access completes on the rising edge
// where n_req=0 and n_wait=1. Until that edge the master keeps a, wen and
// dout unchanged. Read data on din is taken only on the completing edge.
interface boot_multi_loader_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic [AW-1:0] a;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          n_req;
    logic          wen;
    logic          n_wait;

    modport master (
        output a,
        output dout,
        output n_req,
        output wen,
        input  din,
        input  n_wait
    );

    modport slave (
        input  a,
        input  dout,
        input  n_req,
        input  wen,
        output din,
        output n_wait
    );
endinterface

// File: rtl/boot_multi_loader.sv
// Boot copier: holds the core in reset, copies NREG word images stored
// back-to-back from SRC_START into their destination regions, optionally
// verifies a trailing 32-bit additive checksum, then releases the core or
// flags an error. Both outcomes are terminal until rst.
module boot_multi_loader #(
    parameter int                 AW        = 30,
    parameter int                 DW        = 32,
    parameter int                 NREG      = 2,
    parameter logic [AW-1:0]      SRC_START = 30'h0000_2000,
    parameter logic [NREG*AW-1:0] REG_START = {NREG{30'h0}},
    parameter logic [NREG*AW-1:0] REG_SIZE  = {30'd0, 30'd2048},
    parameter bit                 CHK_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                n_rst_core,
    output logic                boot_end,
    output logic                boot_err,
    output logic [2:0]          dbg_state,
    boot_multi_loader_if.master bus
);
    // reg_idx must be able to hold NREG itself (the "table done" value)
    localparam int IW = (NREG < 1) ? 1 : $clog2(NREG + 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_SKIP   = 3'd1,
        S_RD     = 3'd2,
        S_WR     = 3'd3,
        S_SUM_RD = 3'd4,
        S_PASS   = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] cnt;
    logic [IW-1:0] reg_idx;
    logic [IW-1:0] idx_nxt;
    logic [DW-1:0] sum;
    logic [DW-1:0] dout_q;
    logic [AW-1:0] cur_size;
    logic          table_end;
    logic          last_word;

    // Region table lookups; an index of NREG (past the table) reads as 0.
    function automatic logic [AW-1:0] size_at(input logic [IW-1:0] idx);
        size_at = '0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == IW'(k)) begin
                size_at = REG_SIZE[k*AW +: AW];
            end
        end
    endfunction

    function automatic logic [AW-1:0] start_at(input logic [IW-1:0] idx);
        start_at = '0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == IW'(k)) begin
                start_at = REG_START[k*AW +: AW];
            end
        end
    endfunction

    assign cur_size  = size_at(reg_idx);
    assign idx_nxt   = reg_idx + IW'(1);
    assign table_end = (reg_idx == IW'(NREG));
    assign last_word = ((cnt + AW'(1)) == cur_size);
    assign dbg_state = state;
    assign bus.dout  = dout_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; bus states advance only on a completing cycle (n_wait=1).
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: state_nxt = S_SKIP;
            S_SKIP: begin
                if (table_end) begin
                    state_nxt = CHK_EN ? S_SUM_RD : S_PASS;
                end else if (cur_size != '0) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (bus.n_wait) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (bus.n_wait) begin
                    state_nxt = last_word ? S_SKIP : S_RD;
                end
            end
            S_SUM_RD: begin
                if (bus.n_wait) begin
                    state_nxt = (bus.din == sum) ? S_PASS : S_FAIL;
                end
            end
            S_PASS:  state_nxt = S_PASS;
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_INIT;
        endcase
    end

    // Bus drive: address and direction come straight from the state, so they
    // cannot move during a stall; an idle bus shows a=0, wen=1.
    always_comb begin
        bus.n_req = 1'b1;
        bus.wen   = 1'b1;
        bus.a     = '0;
        case (state)
            S_RD: begin
                bus.n_req = 1'b0;
                bus.a     = src;
            end
            S_WR: begin
                bus.n_req = 1'b0;
                bus.wen   = 1'b0;
                bus.a     = dst;
            end
            S_SUM_RD: begin
                bus.n_req = 1'b0;
                bus.a     = src;
            end
            default: begin
                bus.n_req = 1'b1;
            end
        endcase
    end

    // Copy datapath: source/destination pointers, region walk and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            src     <= SRC_START;
            dst     <= '0;
            cnt     <= '0;
            reg_idx <= '0;
            sum     <= '0;
            dout_q  <= '0;
        end else begin
            case (state)
                S_INIT: dst <= start_at('0);
                S_SKIP: begin
                    // zero-size regions are stepped over at one per cycle
                    if (!table_end && cur_size == '0) begin
                        reg_idx <= idx_nxt;
                        dst     <= start_at(idx_nxt);
                    end
                end
                S_RD: begin
                    if (bus.n_wait) begin
                        dout_q <= bus.din;
                        sum    <= sum + bus.din;
                        src    <= src + AW'(1);
                    end
                end
                S_WR: begin
                    if (bus.n_wait) begin
                        if (last_word) begin
                            cnt     <= '0;
                            reg_idx <= idx_nxt;
                            dst     <= start_at(idx_nxt);
                        end else begin
                            cnt <= cnt + AW'(1);
                            dst <= dst + AW'(1);
                        end
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Status flags, registered from the terminal state (one cycle after entry).
    always_ff @(posedge clk) begin
        if (rst) begin
            n_rst_core <= 1'b0;
            boot_end   <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            n_rst_core <= (state == S_PASS);
            boot_end   <= (state == S_PASS) || (state == S_FAIL);
            boot_err   <= (state == S_FAIL);
        end
    end
endmodule
